// File: rtl/pts_pkg.sv
// rtl/pts_pkg.sv - shared types and helpers for the flexible PTS transmitter
package pts_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/flex_bit_timer.sv
// rtl/flex_bit_timer.sv - per-bit cycle counter with clear, enable and rollover strobe
module flex_bit_timer #(
    parameter int PERIOD = 1,
    parameter int W      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic roll_o
);

    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Strobe is combinational so the owning FSM can act in the same cycle.
    assign roll_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = roll_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flex_pts_tx.sv
// rtl/flex_pts_tx.sv - parametrised parallel-to-serial transmitter with hold and done pulse
module flex_pts_tx
    import pts_pkg::*;
#(
    parameter int   NUM_BITS   = 8,
    parameter int   BIT_PERIOD = 1,
    parameter bit   SHIFT_MSB  = 1'b1,
    parameter logic IDLE_VALUE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    input  logic                hold,
    output logic                serial_out,
    output logic                busy,
    output logic                done
);

    localparam int            BW       = $clog2(NUM_BITS);
    localparam int            CW       = cnt_width(BIT_PERIOD);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] sr_q, sr_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                busy_q, done_q, done_d;

    logic tick;
    logic last;
    logic accept;
    logic timer_en;

    assign timer_en = (state_q == SHIFT) && !hold;

    flex_bit_timer #(
        .PERIOD (BIT_PERIOD),
        .W      (CW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept),
        .en_i   (timer_en),
        .roll_o (tick)
    );

    assign last       = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT) && tick;
    assign data_ready = !rst && ((state_q == IDLE) || last);
    assign accept     = data_valid && data_ready;

    assign serial_out = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d      = data_in;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (SHIFT_MSB) begin
                        sr_d = {sr_q[NUM_BITS-2:0], IDLE_VALUE};
                    end else begin
                        sr_d = {IDLE_VALUE, sr_q[NUM_BITS-1:1]};
                    end
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                // After the final shift the register is all fill, so idle drives IDLE_VALUE.
                if (last) begin
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    if (accept) begin
                        sr_d = data_in;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= {NUM_BITS{IDLE_VALUE}};
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= (state_d == SHIFT);
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_flex_pts_tx.sv
// tb/tb_flex_pts_tx.sv - self-checking bench for flex_pts_tx
module tb_flex_pts_tx;

    localparam int   N    = 8;
    localparam int   P    = 1;
    localparam bit   MSB  = 1'b1;
    localparam logic IDLV = 1'b1;

    logic       clk = 1'b0;
    logic       rst, data_valid, hold;
    logic [7:0] data_in;
    logic       data_ready, serial_out, busy, done;

    logic       rst_b, valid_b, hold_b;
    logic [3:0] data_b;
    logic       ready_b, serial_b, busy_b, done_b;

    always #5 clk = ~clk;

    flex_pts_tx u_dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .hold       (hold),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    flex_pts_tx #(
        .NUM_BITS   (4),
        .BIT_PERIOD (3),
        .SHIFT_MSB  (1'b0),
        .IDLE_VALUE (1'b0)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .data_in    (data_b),
        .data_valid (valid_b),
        .data_ready (ready_b),
        .hold       (hold_b),
        .serial_out (serial_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: queue of bits still to appear on the line, current bit first.
    bit m_bits[$];
    int m_rem  = P;
    bit m_done = 1'b0;

    function automatic bit m_ready(input bit r, input bit h);
        return !r && (m_bits.size() == 0 || (m_bits.size() == 1 && m_rem == 1 && !h));
    endfunction

    function automatic bit m_line();
        return (m_bits.size() != 0) ? m_bits[0] : IDLV;
    endfunction

    task automatic m_edge(input bit r, input bit v, input logic [7:0] d, input bit h);
        bit acc;
        acc = v && m_ready(r, h);
        if (r) begin
            m_bits.delete();
            m_rem  = P;
            m_done = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (m_bits.size() != 0 && !h) begin
            m_rem--;
            if (m_rem == 0) begin
                void'(m_bits.pop_front());
                m_rem = P;
                if (m_bits.size() == 0) m_done = 1'b1;
            end
        end
        if (acc) begin
            for (int i = 0; i < N; i++) m_bits.push_back(MSB ? d[N-1-i] : d[i]);
            m_rem = P;
        end
    endtask

    logic s_serial, s_ready, s_busy, s_done;

    // One clock: drive, sample mid-cycle against the model, then advance the model.
    task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit h);
        rst = r; data_valid = v; data_in = d; hold = h;
        @(negedge clk);
        s_serial = serial_out; s_ready = data_ready; s_busy = busy; s_done = done;
        chk("model serial", {31'd0, s_serial}, {31'd0, m_line()});
        chk("model ready",  {31'd0, s_ready},  {31'd0, m_ready(r, h)});
        chk("model busy",   {31'd0, s_busy},   {31'd0, m_bits.size() != 0});
        chk("model done",   {31'd0, s_done},   {31'd0, m_done});
        @(posedge clk);
        m_edge(r, v, d, h);
        #1;
    endtask

    typedef struct {
        bit r, v, h;
        logic [7:0] d;
        bit es, er, eb, ed;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit r, v, input logic [7:0] d, input bit h,
                                input bit es, er, eb, ed);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.h = h;
        t.es = es; t.er = er; t.eb = eb; t.ed = ed;
        tbl.push_back(t);
    endfunction

    initial begin
        logic [7:0]  wa, wb, got8;
        logic [11:0] got12;
        bit          saw_done;

        wa = 8'hA5;
        wb = 8'h3C;
        rst = 1'b1; data_valid = 1'b1; data_in = 8'h00; hold = 1'b0;
        rst_b = 1'b1; valid_b = 1'b0; data_b = 4'h0; hold_b = 1'b0;
        @(posedge clk);
        m_edge(1'b1, 1'b1, 8'h00, 1'b0);
        #1;

        // Reset window with a pending word, then a single word, then back-to-back words.
        add(1, 1, 8'h00, 0, 1, 0, 0, 0);
        add(1, 1, 8'h00, 0, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 0);
        add(0, 1, wa,    0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 8'h00, 0, wa[7-i], i == 7, 1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0, 0);
        add(0, 1, wa,    0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, wb, 0, wa[7-i], i == 7, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 8'h00, 0, wb[7-i], i == 7, 1, i == 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].h);
            chk($sformatf("vec%0d serial", i), {31'd0, s_serial}, {31'd0, tbl[i].es});
            chk($sformatf("vec%0d ready",  i), {31'd0, s_ready},  {31'd0, tbl[i].er});
            chk($sformatf("vec%0d busy",   i), {31'd0, s_busy},   {31'd0, tbl[i].eb});
            chk($sformatf("vec%0d done",   i), {31'd0, s_done},   {31'd0, tbl[i].ed});
        end

        // Hold bit 2 for three extra cycles, then hold during the last bit.
        cyc(0, 1, wa, 0);
        got12 = '0;
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0, 8'h00, (k >= 2 && k <= 4) || k == 10);
            got12[11-k] = s_serial;
            if (k == 10) chk("hold last ready", {31'd0, s_ready}, 32'd0);
            if (k == 11) chk("released last ready", {31'd0, s_ready}, 32'd1);
        end
        chk("hold sequence", {20'd0, got12}, {20'd0, 12'b101111001011});
        cyc(0, 0, 8'h00, 0);
        chk("hold done", {31'd0, s_done}, 32'd1);

        // Reset while bit 4 of 0xF0 is on the line.
        cyc(0, 1, 8'hF0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 0);
        saw_done = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cyc(0, 0, 8'h00, 0);
            if (k == 0) chk("midreset line", {31'd0, s_serial}, 32'd1);
            if (s_done) saw_done = 1'b1;
        end
        chk("midreset no done", {31'd0, saw_done}, 32'd0);
        cyc(0, 1, 8'h81, 0);
        got8 = '0;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 8'h00, 0);
            got8[7-k] = s_serial;
        end
        chk("post reset word", {24'd0, got8}, 32'h81);
        cyc(0, 0, 8'h00, 0);

        // Randomised traffic against the model.
        for (int k = 0; k < 800; k++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                8'($urandom), $urandom_range(0, 4) == 0);
        end
        cyc(1, 0, 8'h00, 0);

        // Second instance: 4 bits, LSB first, 3 clocks per bit, idles low.
        rst_b = 1'b0; valid_b = 1'b1; data_b = 4'b0011;
        @(negedge clk);
        chk("b idle ready", {31'd0, ready_b}, 32'd1);
        chk("b idle line",  {31'd0, serial_b}, 32'd0);
        @(posedge clk); #1;
        valid_b = 1'b0; data_b = 4'hF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("b bit%0d", k), {31'd0, serial_b}, {31'd0, k < 6});
            chk($sformatf("b busy%0d", k), {31'd0, busy_b}, 32'd1);
            chk($sformatf("b done%0d", k), {31'd0, done_b}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("b end line", {31'd0, serial_b}, 32'd0);
        chk("b end done", {31'd0, done_b}, 32'd1);
        chk("b end busy", {31'd0, busy_b}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b done cleared", {31'd0, done_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
